id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

Decode-to-execute pipeline stage register sitting directly downstream of `register_file`. It captures the two read operands (`rd_data_1`/`rd_data_2`) together with the decoded instruction fields, and presents them to the execute stage behind a valid/ready handshake. While an instruction is captured or held, the block keeps its operands coherent with writeback traffic on the register file's write port. It also supports pipeline flush and counts downstream stall cycles.

## Interface
- `XLEN`, 32, datapath width
- `REG_ADDR_W`, 5, register index width (x0..x31)
- `clk` input 1 — single clock, all state updates on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `in_valid` input 1 — decode presents an instruction
- `in_ready` output 1 — stage can accept this cycle
- `rd_reg_1`, `rd_reg_2` input REG_ADDR_W — source indices, same values driven to `register_file`
- `rd_data_1`, `rd_data_2` input XLEN — combinational read data from `register_file`
- `in_rd` input REG_ADDR_W — destination index
- `in_imm`, `in_pc` input XLEN — decoded immediate, instruction PC
- `in_ctrl` input `ctrl_t` — decoded control bundle
- `wr_en`, `wr_reg`, `wr_data` input 1/REG_ADDR_W/XLEN — writeback port, same nets as `register_file` write port
- `flush` input 1 — kill stage contents
- `out_valid` output 1, `out_ready` input 1 — handshake to execute
- `out_rs1`, `out_rs2`, `out_rd` output REG_ADDR_W; `out_op_a`, `out_op_b`, `out_imm`, `out_pc` output XLEN; `out_ctrl` output `ctrl_t`
- `stall_cycles` output 32 — saturating count of downstream stall cycles

## Operation
- One-entry register; `in_ready = !out_valid || out_ready` (combinational, no dependence on `in_valid`).
- Capture: `in_valid && in_ready && !flush` → all `out_*` payload fields load, `out_valid` ← 1.
- Drain without refill: `out_valid && out_ready && !(in_valid && in_ready)` → `out_valid` ← 0; payload holds its last value.
- Capture bypass: the register file commits writes at the clock edge, so same-cycle read data is stale. At capture, if `wr_en && wr_reg == rd_reg_N && wr_reg != 0`, then `out_op_N` ← `wr_data`; otherwise `out_op_N` ← `rd_data_N`.
- Hold refresh: while held (`out_valid && !out_ready`), if `wr_en && wr_reg == out_rsN && wr_reg != 0`, then `out_op_N` ← `wr_data`. Both operands update if both indices match.
- x0 never bypasses or refreshes; an operand sourced from x0 stays at the value read (0).
- Flush has priority over capture and hold: `out_valid` ← 0 at the next edge, input is not accepted, and the payload is unchanged. `in_ready` is not gated by `flush`; upstream must treat a flush cycle as not-accepted.
- `stall_cycles` increments on each edge where `out_valid && !out_ready && !flush`, and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (asynchronous, immediate): `out_valid`=0, all payload outputs=0, `out_ctrl`='0, `stall_cycles`=0; so `in_ready`=1 while in reset.
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready` is held at 1.
- Simultaneous drain and capture in one cycle: new payload loads, and `out_valid` stays 1.
- Reset asserted mid-hold drops the held instruction; no partial state survives.
- Writeback on the same edge as drain (no refill): no refresh is required, since the entry is leaving.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`, `REG_ADDR_W`
  - `ctrl_t` packed struct: `alu_op`[3:0], `alu_src_imm`, `mem_rd`, `mem_wr`, `reg_wr`, `wb_sel`[1:0]
- Sub-module `wb_bypass`: combinational operand select.
  - Inputs: index, read data, `wr_en`/`wr_reg`/`wr_data`.
  - Output: bypassed operand.
  - Instantiated once per operand; used for both capture and hold refresh.

## Test plan
- Reset then idle: `rst` pulse → `out_valid`=0, `out_op_a`=0, `stall_cycles`=0, `in_ready`=1.
- Capture bypass: `rd_reg_1`=5, `rd_data_1`=0x1111_1111, same cycle `wr_en`=1, `wr_reg`=5, `wr_data`=0xDEAD_BEEF → next cycle `out_op_a`=0xDEAD_BEEF, `out_valid`=1.
- x0 guard: `rd_reg_2`=0, `wr_en`=1, `wr_reg`=0, `wr_data`=0xFFFF_FFFF → `out_op_b`=0.
- Hold refresh: `out_ready`=0 for 3 cycles with `out_rs2`=15, and a write of 0x0000_FFFF to x15 in cycle 2 → `out_op_b`=0x0000_FFFF from cycle 3, `in_ready`=0 throughout, `stall_cycles`=3.
- Flush vs capture: `in_valid`=1, `flush`=1, `out_ready`=1 → next cycle `out_valid`=0, payload unchanged.
- Random: 10000 cycles of random valid/ready/flush/writeback against a reference register-file model → every accepted instruction's `out_op_a`/`out_op_b` equals the model value at the handshake cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: datapath widths, decoded control bundle and the
// writeback-hit predicate used by operand bypassing.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src_imm;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic [1:0] wb_sel;
   } ctrl_t;

   // x0 is hardwired to zero, so a write to it must never be forwarded.
   function automatic logic wb_hit(input logic                  wr_en,
                                   input logic [REG_ADDR_W-1:0] wr_reg,
                                   input logic [REG_ADDR_W-1:0] idx);
      return wr_en && (wr_reg == idx) && (wr_reg != '0);
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-side input channel and execute-side output channel of the ID/EX stage.
// The stage register is the slave; the surrounding pipeline is the master.
interface id_ex_stage_reg_if;
   import riscv_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [REG_ADDR_W-1:0] rd_reg_1;
   logic [REG_ADDR_W-1:0] rd_reg_2;
   logic [XLEN-1:0]       rd_data_1;
   logic [XLEN-1:0]       rd_data_2;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [XLEN-1:0]       in_imm;
   logic [XLEN-1:0]       in_pc;
   ctrl_t                 in_ctrl;

   logic                  out_valid;
   logic                  out_ready;
   logic [REG_ADDR_W-1:0] out_rs1;
   logic [REG_ADDR_W-1:0] out_rs2;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [XLEN-1:0]       out_op_a;
   logic [XLEN-1:0]       out_op_b;
   logic [XLEN-1:0]       out_imm;
   logic [XLEN-1:0]       out_pc;
   ctrl_t                 out_ctrl;

   modport slave (
      input  in_valid, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2, in_rd, in_imm, in_pc, in_ctrl,
      output in_ready,
      output out_valid, out_rs1, out_rs2, out_rd, out_op_a, out_op_b, out_imm, out_pc, out_ctrl,
      input  out_ready
   );

   modport master (
      output in_valid, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2, in_rd, in_imm, in_pc, in_ctrl,
      input  in_ready,
      input  out_valid, out_rs1, out_rs2, out_rd, out_op_a, out_op_b, out_imm, out_pc, out_ctrl,
      output out_ready
   );

endinterface

// File: rtl/wb_bypass.sv
// Combinational operand select: forwards the writeback value when the write
// port targets this operand's source register, otherwise passes the read data.
module wb_bypass
   import riscv_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] idx_i,
   input  logic [XLEN-1:0]       rd_data_i,
   input  logic                  wr_en_i,
   input  logic [REG_ADDR_W-1:0] wr_reg_i,
   input  logic [XLEN-1:0]       wr_data_i,
   output logic [XLEN-1:0]       op_o
);

   always_comb begin
      op_o = rd_data_i;
      if (wb_hit(wr_en_i, wr_reg_i, idx_i)) begin
         op_o = wr_data_i;
      end
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// One-entry ID/EX pipeline register with valid/ready handshake, writeback-coherent
// operands (capture bypass and hold refresh), flush and a saturating stall counter.
module id_ex_stage_reg
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   id_ex_stage_reg_if.slave      bus,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_reg,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  flush,
   output logic [31:0]           stall_cycles
);

   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
   logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]       op_a_q, op_a_d;
   logic [XLEN-1:0]       op_b_q, op_b_d;
   logic [XLEN-1:0]       imm_q, imm_d;
   logic [XLEN-1:0]       pc_q, pc_d;
   ctrl_t                 ctrl_q, ctrl_d;
   logic [31:0]           stall_q, stall_d;

   logic                  in_ready;
   logic                  capture;
   logic                  hold;
   logic [REG_ADDR_W-1:0] byp_idx_a, byp_idx_b;
   logic [XLEN-1:0]       byp_src_a, byp_src_b;
   logic [XLEN-1:0]       byp_a, byp_b;

   assign in_ready = !valid_q || bus.out_ready;
   assign capture  = bus.in_valid && in_ready && !flush;
   assign hold     = valid_q && !bus.out_ready;

   // Capture and hold are mutually exclusive, so one bypass per operand serves both:
   // while holding it refreshes the stored operand, otherwise it fixes up fresh read data.
   assign byp_idx_a = hold ? rs1_q  : bus.rd_reg_1;
   assign byp_src_a = hold ? op_a_q : bus.rd_data_1;
   assign byp_idx_b = hold ? rs2_q  : bus.rd_reg_2;
   assign byp_src_b = hold ? op_b_q : bus.rd_data_2;

   wb_bypass u_bypass_a (
      .idx_i     (byp_idx_a),
      .rd_data_i (byp_src_a),
      .wr_en_i   (wr_en),
      .wr_reg_i  (wr_reg),
      .wr_data_i (wr_data),
      .op_o      (byp_a)
   );

   wb_bypass u_bypass_b (
      .idx_i     (byp_idx_b),
      .rd_data_i (byp_src_b),
      .wr_en_i   (wr_en),
      .wr_reg_i  (wr_reg),
      .wr_data_i (wr_data),
      .op_o      (byp_b)
   );

   always_comb begin
      valid_d = valid_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ctrl_d  = ctrl_q;
      stall_d = stall_q;

      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
         rs1_d   = bus.rd_reg_1;
         rs2_d   = bus.rd_reg_2;
         rd_d    = bus.in_rd;
         op_a_d  = byp_a;
         op_b_d  = byp_b;
         imm_d   = bus.in_imm;
         pc_d    = bus.in_pc;
         ctrl_d  = bus.in_ctrl;
      end else if (hold) begin
         op_a_d  = byp_a;
         op_b_d  = byp_b;
      end else if (valid_q) begin
         valid_d = 1'b0;
      end

      if (hold && !flush && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ctrl_q  <= '0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ctrl_q  <= ctrl_d;
         stall_q <= stall_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_rs1   = rs1_q;
   assign bus.out_rs2   = rs2_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_op_a  = op_a_q;
   assign bus.out_op_b  = op_b_q;
   assign bus.out_imm   = imm_q;
   assign bus.out_pc    = pc_q;
   assign bus.out_ctrl  = ctrl_q;
   assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed and randomized bench for id_ex_stage_reg against a reference register file.
module tb_id_ex_stage_reg;
   import riscv_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic        flush;
   logic [31:0] stall_cycles;

   id_ex_stage_reg_if bus ();

   id_ex_stage_reg dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .wr_en        (wr_en),
      .wr_reg       (wr_reg),
      .wr_data      (wr_data),
      .flush        (flush),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2,
                           input logic [31:0] d2, input logic [4:0] rd, input logic [31:0] imm,
                           input logic [31:0] pc, input ctrl_t c);
      bus.in_valid  = 1'b1;
      bus.rd_reg_1  = r1;
      bus.rd_data_1 = d1;
      bus.rd_reg_2  = r2;
      bus.rd_data_2 = d2;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
      bus.in_pc     = pc;
      bus.in_ctrl   = c;
   endtask

   logic [31:0] rf [32];
   ent_t        q[$];
   ent_t        e;
   logic [31:0] m_stall;
   logic        exp_ready;

   initial begin
      rst = 1'b1;
      drive_in(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, ctrl_t'(10'h0));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      wr_en = 1'b0; wr_reg = '0; wr_data = '0; flush = 1'b0;

      // Reset state
      #12;
      check("rst_valid", bus.out_valid, 0);
      check("rst_op_a", bus.out_op_a, 0);
      check("rst_stall", stall_cycles, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_ctrl", bus.out_ctrl, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Capture bypass: write to x5 in the capture cycle wins over stale read data
      drive_in(5'd5, 32'h1111_1111, 5'd0, 32'd0, 5'd3, 32'h10, 32'h100, ctrl_t'(10'h2A5));
      bus.out_ready = 1'b1;
      wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hDEAD_BEEF;
      step();
      check("byp_op_a", bus.out_op_a, 32'hDEAD_BEEF);
      check("byp_valid", bus.out_valid, 1);
      check("byp_pc", bus.out_pc, 32'h100);
      check("byp_rd", bus.out_rd, 3);
      check("byp_ctrl", bus.out_ctrl, 10'h2A5);

      // x0 guard, also a simultaneous drain and capture
      drive_in(5'd7, 32'h77, 5'd0, 32'd0, 5'd4, 32'h20, 32'h104, ctrl_t'(10'h15A));
      wr_en = 1'b1; wr_reg = 5'd0; wr_data = 32'hFFFF_FFFF;
      step();
      check("x0_op_b", bus.out_op_b, 0);
      check("x0_op_a", bus.out_op_a, 32'h77);
      check("x0_valid", bus.out_valid, 1);
      check("x0_pc", bus.out_pc, 32'h104);

      // Hold refresh on x15
      drive_in(5'd1, 32'h1, 5'd15, 32'hAAAA, 5'd6, 32'h30, 32'h108, ctrl_t'(10'h0F0));
      wr_en = 1'b0;
      step();
      check("hold_cap_op_b", bus.out_op_b, 32'hAAAA);
      bus.out_ready = 1'b0;
      drive_in(5'd2, 32'h2, 5'd2, 32'h2, 5'd2, 32'h2, 32'h999, ctrl_t'(10'h001));
      for (int i = 1; i <= 3; i++) begin
         wr_en = (i == 2); wr_reg = 5'd15; wr_data = 32'h0000_FFFF;
         @(negedge clk);
         check("hold_in_ready", bus.in_ready, 0);
         step();
         if (i >= 2) check("hold_op_b", bus.out_op_b, 32'h0000_FFFF);
      end
      check("hold_stall", stall_cycles, 3);
      check("hold_pc", bus.out_pc, 32'h108);
      check("hold_op_a", bus.out_op_a, 32'h1);

      // Flush beats capture; payload unchanged
      wr_en = 1'b0;
      bus.out_ready = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", bus.out_valid, 0);
      check("flush_pc", bus.out_pc, 32'h108);
      check("flush_op_b", bus.out_op_b, 32'h0000_FFFF);
      check("flush_stall", stall_cycles, 3);

      // Drain without refill; writeback on the drain edge
      drive_in(5'd9, 32'h9, 5'd10, 32'hA, 5'd11, 32'h40, 32'h200, ctrl_t'(10'h3FF));
      step();
      check("drain_cap_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      wr_en = 1'b1; wr_reg = 5'd9; wr_data = 32'h5;
      step();
      wr_en = 1'b0;
      check("drain_valid", bus.out_valid, 0);
      check("drain_pc", bus.out_pc, 32'h200);

      // Reset mid-hold
      drive_in(5'd3, 32'h33, 5'd4, 32'h44, 5'd12, 32'h50, 32'h300, ctrl_t'(10'h1C3));
      step();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      step();
      step();
      check("mid_stall", stall_cycles, 5);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_pc", bus.out_pc, 0);
      check("mid_rst_op_a", bus.out_op_a, 0);
      check("mid_rst_stall", stall_cycles, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Random traffic against a reference register file
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
      m_stall = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.rd_reg_1  = 5'($urandom_range(0, 7));
         bus.rd_reg_2  = 5'($urandom_range(0, 7));
         bus.rd_data_1 = rf[bus.rd_reg_1];
         bus.rd_data_2 = rf[bus.rd_reg_2];
         bus.in_rd     = 5'($urandom_range(0, 31));
         bus.in_imm    = $urandom;
         bus.in_pc     = cyc;
         bus.in_ctrl   = ctrl_t'(10'($urandom));
         wr_en         = 1'($urandom_range(0, 1));
         wr_reg        = 5'($urandom_range(0, 7));
         wr_data       = $urandom;
         flush         = ($urandom_range(0, 19) == 0);
         bus.out_ready = ($urandom_range(0, 9) < 6);

         @(negedge clk);
         exp_ready = (q.size() == 0) || bus.out_ready;
         check("rnd_in_ready", bus.in_ready, exp_ready);
         check("rnd_valid", bus.out_valid, q.size() != 0);
         if (q.size() != 0 && bus.out_ready && !flush) begin
            check("rnd_pc", bus.out_pc, q[0].pc);
            check("rnd_op_a", bus.out_op_a, rf[q[0].rs1]);
            check("rnd_op_b", bus.out_op_b, rf[q[0].rs2]);
         end

         @(posedge clk);
         if (q.size() != 0 && !bus.out_ready && !flush && m_stall != '1) m_stall++;
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && exp_ready) begin
               e.pc  = bus.in_pc;
               e.rs1 = bus.rd_reg_1;
               e.rs2 = bus.rd_reg_2;
               q.push_back(e);
            end
         end
         if (wr_en && wr_reg != 5'd0) rf[wr_reg] = wr_data;
         #1;
      end
      check("rnd_stall", stall_cycles, m_stall);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
